// File: rtl/exam_operand_engine.sv
`default_nettype none
// ============================================================================
// Module   : exam_operand_engine
// Purpose  : Responder side of the exam operand start/done handshake.
//            Latches four operands, computes a bit-serial popcount/parity of
//            A and C, then multiplies the low bytes of B and D by shift-add,
//            and presents the results on g/h with a registered done flag.
// Revision : 1.0 - initial release
// ============================================================================
module exam_operand_engine #(
    parameter int W     = 16,
    parameter int MUL_W = 8
) (
    input  logic         clk,
    input  logic         rst,      // asynchronous, active-low
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         start,
    output logic [W-1:0] g,
    output logic [W-1:0] h,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        POP  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Last counter value of each serial phase.
    localparam logic [3:0] C_POP_LAST = 4'(W - 1);
    localparam logic [3:0] C_MUL_LAST = 4'(MUL_W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     sa_q, sa_d;
    logic [W-1:0]     sc_q, sc_d;
    logic [MUL_W-1:0] mb_q, mb_d;
    logic [W-1:0]     md_ext_q, md_ext_d;
    logic [4:0]       pa_q, pa_d;
    logic [4:0]       pc_q, pc_d;
    logic [W-1:0]     prod_q, prod_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [W-1:0]     g_q, g_d;
    logic [W-1:0]     h_q, h_d;
    logic             done_q, done_d;

    // Upper halves of b and d are architecturally ignored.
    logic unused_upper;
    assign unused_upper = ^{b[W-1:MUL_W], d[W-1:MUL_W]};

    // Next-state and datapath: one serial step per cycle in POP and MUL.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sc_d     = sc_q;
        mb_d     = mb_q;
        md_ext_d = md_ext_q;
        pa_d     = pa_q;
        pc_d     = pc_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        g_d      = g_q;
        h_d      = h_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sa_d     = a;
                sc_d     = c;
                mb_d     = b[MUL_W-1:0];
                md_ext_d = {{(W-MUL_W){1'b0}}, d[MUL_W-1:0]};
                pa_d     = '0;
                pc_d     = '0;
                prod_d   = '0;
                cnt_d    = '0;
                state_d  = POP;
            end
            POP: begin
                pa_d  = pa_q + {4'd0, sa_q[0]};
                pc_d  = pc_q + {4'd0, sc_q[0]};
                sa_d  = sa_q >> 1;
                sc_d  = sc_q >> 1;
                if (cnt_q == C_POP_LAST) begin
                    cnt_d   = '0;
                    state_d = MUL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            MUL: begin
                if (mb_q[0]) begin
                    prod_d = prod_q + md_ext_q;
                end
                mb_d     = mb_q >> 1;
                md_ext_d = md_ext_q << 1;
                if (cnt_q == C_MUL_LAST) begin
                    // Results are written together with done so that done=1
                    // always qualifies stable g/h. Parity bit is 1 for even
                    // popcount of a.
                    cnt_d   = '0;
                    state_d = DONE;
                    g_d     = {~pa_q[0], {(W-11){1'b0}}, pc_q, pa_q};
                    h_d     = prod_d;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sc_q     <= '0;
            mb_q     <= '0;
            md_ext_q <= '0;
            pa_q     <= '0;
            pc_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            g_q      <= '0;
            h_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sc_q     <= sc_d;
            mb_q     <= mb_d;
            md_ext_q <= md_ext_d;
            pa_q     <= pa_d;
            pc_q     <= pc_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            g_q      <= g_d;
            h_q      <= h_d;
            done_q   <= done_d;
        end
    end

    assign g    = g_q;
    assign h    = h_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/exam_operand_engine.md
# exam_operand_engine

Responder end of the exam operand start/done handshake. The operand-entry front end captures four 16-bit operands, raises `start`, and waits for `done`. This block latches the operands, runs a bit-serial popcount/parity pass and a shift-add multiply, then presents `g`/`h` and raises `done`. It replaces the ad-hoc student compute module and has a fixed, verifiable latency.

## Interface
- `W`, 16: operand and result width; only 16 is supported.
- `MUL_W`, 8: multiplier operand width (low bits of `b`, `d`); `2*MUL_W` must equal `W`.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous and active-low; one clock.
- `a`  in  W  operand A, popcount and parity source.
- `b`  in  W  operand B; only `b[MUL_W-1:0]` is used.
- `c`  in  W  operand C, popcount source.
- `d`  in  W  operand D; only `d[MUL_W-1:0]` is used.
- `start`  in  1  level request; may be held high indefinitely.
- `g`  out  W  registered result G.
- `h`  out  W  registered result H.
- `done`  out  1  registered completion flag.

## Operation
- States: `IDLE`, `LOAD`, `POP`, `MUL`, `DONE`.
- `IDLE`:
  - `start`=1 → `LOAD`.
  - Otherwise stay; `done`=0.
- `LOAD`:
  - Copy `a`, `c` to shift registers `sa`, `sc`.
  - Copy `b[7:0]` to `mb`, `d[7:0]` to `md`.
  - Clear popcount accumulators `pa`, `pc` (5 bits each), the product accumulator (16 bits) and the bit counter.
  - → `POP`.
- `POP`, 16 cycles:
  - Each cycle `pa += sa[0]`, `pc += sc[0]`, then shift `sa` and `sc` right by 1.
  - Counter 0..15; at count 15 → `MUL` and clear the counter.
- `MUL`, 8 cycles:
  - Each cycle, if `mb[0]` then `prod += md_ext` (`md` zero-extended to 16 bits).
  - Then `mb >>= 1`, `md_ext <<= 1`.
  - At count 7 → `DONE`.
- On entry to `DONE` (same edge as the `MUL`→`DONE` transition):
  - `g[4:0]` = `pa`; `g[9:5]` = `pc`; `g[14:10]` = 0.
  - `g[15]` = odd-parity bit of `a` = ~^`a`, i.e. 1 when `pa` is even.
  - `h` = `prod`, which cannot overflow (max 255*255 = 0xFE01).
  - `done` <= 1.
- `DONE`:
  - `start`=1 → stay; `done` stays 1; no recompute.
  - `start`=0 → `IDLE`; `done` <= 0 on that edge.
- Outputs `g`, `h` change only on entry to `DONE` or on reset. They hold through `IDLE` and any later run until the new result is written.
- Operand changes after the `LOAD` edge have no effect on the current run.
- `start` dropping during `LOAD`/`POP`/`MUL` is ignored; the run completes, then `DONE` exits to `IDLE` on the next edge.
- Unused state encodings → `IDLE`.

## Timing
- Reset (async assert, `rst`=0): state `IDLE`; `g`=0, `h`=0, `done`=0; all working registers 0.
- Reset mid-run aborts immediately; no partial result reaches `g`/`h`.
- Latency: counting the first rising edge that samples `start`=1 in `IDLE` as edge 1:
  - Edge 2: `LOAD`.
  - Edges 3–18: `POP`.
  - Edges 19–26: `MUL`.
  - `g`, `h`, `done` become valid after edge 26.
- Minimum spacing between runs: `done` falls on the edge after `start`=0 is sampled in `DONE`. A new `start`=1 is accepted one edge after that, from `IDLE`.
- `done` and `g`/`h` update on the same edge, so `done`=1 always qualifies stable results.

## Test plan
- `a`=0xFFFF, `c`=0x0000, `b`=0x00FF, `d`=0x00FF, `start` held high → after edge 26: `g`=0x8010, `h`=0xFE01, `done`=1; `done` still 1 and `g`/`h` unchanged 50 cycles later.
- `a`=0x0001, `c`=0x8001, `b`=0x1203, `d`=0xAB05 → `g`=0x0041, `h`=0x000F; upper bytes of `b`/`d` ignored.
- All operands 0 → `g`=0x8000, `h`=0x0000, `done` rises exactly at edge 26, never earlier.
- Run 1 as in scenario 1; change `a` to 0x0000 at edge 5; drop `start` at edge 10 → result still `g`=0x8010, `h`=0xFE01 at edge 26. `done` falls at edge 27; `g`/`h` hold.
- After a completed run, lower `start`, set `a`=0x0003, `c`=0x0007, `b`=0x0010, `d`=0x0010, raise `start` → new `g`=0x8062, `h`=0x0100. The old values hold until the new `done` edge.
- Assert `rst`=0 asynchronously at edge 12 of a run → `g`, `h`, `done` = 0 immediately. After release with `start`=1, the full 26-edge sequence repeats and yields the correct result.
